// File: rtl/if_fetch_ctrl_if.sv
// DRAM/cache read channel between the fetch controller (master) and the memory side (slave).
interface if_fetch_ctrl_if;
  logic        dram_req;
  logic [63:0] dram_addr;
  logic        dram_ready_in;
  logic [31:0] dram_rdata;

  modport master (
    output dram_req,
    output dram_addr,
    input  dram_ready_in,
    input  dram_rdata
  );

  modport slave (
    input  dram_req,
    input  dram_addr,
    output dram_ready_in,
    output dram_rdata
  );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch-channel controller: steers IFP fetches to the boot ROM or DRAM, holds the
// PC while a DRAM read is outstanding, buffers stalled responses and drops flushed ones.
module if_fetch_ctrl #(
  parameter logic [63:0] ROM_BASE  = 64'h0000_0000_0000_0000,
  parameter logic [63:0] ROM_SIZE  = 64'h1000,
  parameter logic [63:0] DRAM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] DRAM_SIZE = 64'h1000_0000,
  parameter int          TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [63:0]             pc_IFP,
  input  logic                    pc_valid,
  input  logic                    stall_in,
  input  logic                    flush,
  if_fetch_ctrl_if.master         dram,
  output logic                    if_channel_sel,
  output logic [31:0]             ifr_dram_dout,
  output logic                    ifr_dram_ready,
  output logic                    fetch_stall,
  output logic                    fetch_fault,
  output logic [63:0]             fault_pc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_q, buf_d;
  logic [63:0]   fault_pc_q, fault_pc_d;

  logic          req_c, sel_c, rdy_c, stall_c, fault_c;
  logic [63:0]   addr_c;
  logic [31:0]   dout_c;

  // Window test via offset: a PC below the base wraps to a huge offset, so one
  // unsigned compare covers both bounds as long as base+size does not overflow.
  logic [63:0] rom_off, dram_off;
  logic        rom_hit, dram_hit;

  assign rom_off  = pc_IFP - ROM_BASE;
  assign dram_off = pc_IFP - DRAM_BASE;
  assign rom_hit  = rom_off < ROM_SIZE;
  assign dram_hit = dram_off < DRAM_SIZE;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    fault_pc_d = fault_pc_q;
    req_c      = 1'b0;
    addr_c     = '0;
    sel_c      = 1'b0;
    dout_c     = '0;
    rdy_c      = 1'b0;
    stall_c    = 1'b0;
    fault_c    = 1'b0;

    unique case (state_q)
      S_RUN: begin
        // A flush redirects the PC, so the current fetch neither requests nor faults.
        if (pc_valid && !stall_in && !flush) begin
          if (dram_hit) begin
            req_c   = 1'b1;
            addr_c  = pc_IFP;
            sel_c   = 1'b1;
            stall_c = 1'b1;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else if (!rom_hit) begin
            fault_c    = 1'b1;
            fault_pc_d = pc_IFP;
          end
        end
      end

      S_WAIT: begin
        sel_c   = 1'b1;
        stall_c = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (flush) begin
          state_d = dram.dram_ready_in ? S_RUN : S_DISCARD;
        end else if (dram.dram_ready_in && !stall_in) begin
          rdy_c   = 1'b1;
          dout_c  = dram.dram_rdata;
          stall_c = 1'b0;
          state_d = S_RUN;
        end else if (dram.dram_ready_in) begin
          buf_d   = dram.dram_rdata;
          state_d = S_HOLD;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Last allowed wait cycle without data: give up and drain the late answer.
          fault_c    = 1'b1;
          fault_pc_d = pc_IFP;
          state_d    = S_DISCARD;
        end
      end

      S_HOLD: begin
        sel_c   = 1'b1;
        stall_c = stall_in;
        if (flush) begin
          buf_d   = '0;
          state_d = S_RUN;
        end else begin
          rdy_c  = 1'b1;
          dout_c = buf_q;
          if (!stall_in) begin
            state_d = S_RUN;
          end
        end
      end

      S_DISCARD: begin
        sel_c   = 1'b1;
        stall_c = 1'b1;
        if (dram.dram_ready_in) begin
          state_d = S_RUN;
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= S_RUN;
      cnt_q      <= '0;
      buf_q      <= '0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  // Reset overrides everything, including the combinational request and fault strobes.
  assign dram.dram_req  = req_c & ~reset;
  assign dram.dram_addr = reset ? '0 : addr_c;
  assign if_channel_sel = sel_c & ~reset;
  assign ifr_dram_dout  = reset ? '0 : dout_c;
  assign ifr_dram_ready = rdy_c & ~reset;
  assign fetch_stall    = stall_c & ~reset;
  assign fetch_fault    = fault_c & ~reset;
  assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a transaction-level model queues the expected
// outputs per cycle; a monitor pops and compares them on the falling edge.
module tb_if_fetch_ctrl;

  localparam logic [63:0] ROM_BASE  = 64'h0;
  localparam logic [63:0] ROM_SIZE  = 64'h1000;
  localparam logic [63:0] DRAM_BASE = 64'h8000_0000;
  localparam logic [63:0] DRAM_SIZE = 64'h1000_0000;
  localparam int          TIMEOUT   = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc_IFP;
  logic        pc_valid, stall_in, flush;
  logic        if_channel_sel, ifr_dram_ready, fetch_stall, fetch_fault;
  logic [31:0] ifr_dram_dout;
  logic [63:0] fault_pc;

  if_fetch_ctrl_if dram_bus ();

  if_fetch_ctrl #(
    .ROM_BASE (ROM_BASE),
    .ROM_SIZE (ROM_SIZE),
    .DRAM_BASE(DRAM_BASE),
    .DRAM_SIZE(DRAM_SIZE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_IFP        (pc_IFP),
    .pc_valid      (pc_valid),
    .stall_in      (stall_in),
    .flush         (flush),
    .dram          (dram_bus),
    .if_channel_sel(if_channel_sel),
    .ifr_dram_dout (ifr_dram_dout),
    .ifr_dram_ready(ifr_dram_ready),
    .fetch_stall   (fetch_stall),
    .fetch_fault   (fetch_fault),
    .fault_pc      (fault_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [63:0] addr;
    logic        sel;
    logic [31:0] dout;
    logic        rdy;
    logic        stall;
    logic        fault;
    logic [63:0] fpc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   checking = 0;
  int   cycle_no = 0;

  // Reference model state: is a read outstanding, is its answer doomed, is an answer parked.
  bit          m_busy = 0, m_kill = 0, m_held = 0;
  logic [31:0] m_buf = '0;
  int          m_waited = 0;
  logic [63:0] m_fpc = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle_no, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [63:0] a, input logic [63:0] base,
                                input logic [63:0] size);
    return (a >= base) && (a < base + size);
  endfunction

  task automatic model_step(input logic [63:0] pc, input bit valid, input bit stall,
                            input bit fl, input bit rdy, input logic [31:0] rdata,
                            input bit rst);
    exp_t e;
    e     = '0;
    e.fpc = m_fpc;
    if (rst) begin
      m_busy = 0; m_kill = 0; m_held = 0; m_fpc = '0;
    end else if (m_held) begin
      e.sel   = 1; e.stall = stall;
      if (fl) m_held = 0;
      else begin
        e.rdy = 1; e.dout = m_buf;
        if (!stall) m_held = 0;
      end
    end else if (m_busy && !m_kill) begin
      e.sel = 1; e.stall = 1;
      m_waited++;
      if (fl) begin
        if (rdy) m_busy = 0; else m_kill = 1;
      end else if (rdy) begin
        m_busy = 0;
        if (!stall) begin
          e.rdy = 1; e.dout = rdata; e.stall = 0;
        end else begin
          m_held = 1; m_buf = rdata;
        end
      end else if (m_waited == TIMEOUT) begin
        e.fault = 1; m_fpc = pc; m_kill = 1;
      end
    end else if (m_busy) begin
      e.sel = 1; e.stall = 1;
      if (rdy) begin m_busy = 0; m_kill = 0; end
    end else if (valid && !stall && !fl) begin
      if (in_win(pc, DRAM_BASE, DRAM_SIZE)) begin
        e.req = 1; e.addr = pc; e.sel = 1; e.stall = 1;
        m_busy = 1; m_waited = 0;
      end else if (!in_win(pc, ROM_BASE, ROM_SIZE)) begin
        e.fault = 1; m_fpc = pc;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [63:0] pc, input bit valid, input bit stall, input bit fl,
                     input bit rdy, input logic [31:0] rdata, input bit rst);
    @(posedge clk);
    #1;
    reset                  = rst;
    pc_IFP                 = pc;
    pc_valid               = valid;
    stall_in               = stall;
    flush                  = fl;
    dram_bus.dram_ready_in = rdy;
    dram_bus.dram_rdata    = rdata;
    model_step(pc, valid, stall, fl, rdy, rdata, rst);
    checking = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(64'h0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (checking) begin
        cycle_no++;
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 64'd0, 64'd1);
        end else begin
          e = exp_q.pop_front();
          check("dram_req",       64'(dram_bus.dram_req),  64'(e.req));
          check("dram_addr",      dram_bus.dram_addr,      e.addr);
          check("if_channel_sel", 64'(if_channel_sel),     64'(e.sel));
          check("ifr_dram_ready", 64'(ifr_dram_ready),     64'(e.rdy));
          check("ifr_dram_dout",  64'(ifr_dram_dout),      64'(e.dout));
          check("fetch_stall",    64'(fetch_stall),        64'(e.stall));
          check("fetch_fault",    64'(fetch_fault),        64'(e.fault));
          check("fault_pc",       fault_pc,                e.fpc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] unm [5];
    logic [63:0] pc;
    int          cat, rdy_div;
    unm[0] = 64'h1000;
    unm[1] = 64'h4000;
    unm[2] = 64'h7FFF_FFFC;
    unm[3] = 64'h9000_0000;
    unm[4] = 64'hFFFF_FFFF_FFFF_FFFC;

    reset = 1; pc_IFP = '0; pc_valid = 0; stall_in = 0; flush = 0;
    dram_bus.dram_ready_in = 0; dram_bus.dram_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset state, checked while reset is still asserted with a DRAM PC applied.
    cyc(64'h8000_0000, 1, 0, 0, 0, 32'h0, 1);
    cyc(64'h0, 0, 0, 0, 0, 32'h0, 0);

    // ROM fetch.
    for (int i = 0; i < 4; i++) cyc(64'h100 + 64'(i * 4), 1, 0, 0, 0, 32'h0, 0);

    // DRAM fetch, three stalled cycles then the accept.
    cyc(64'h8000_0000, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0000, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0000, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0000, 1, 0, 0, 1, 32'h0000_0013, 0);
    cyc(64'h104, 1, 0, 0, 0, 32'h0, 0);

    // Ready during downstream stall -> HOLD, release when stall drops.
    cyc(64'h8000_0010, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0010, 1, 1, 0, 1, 32'hDEAD_BEEF, 0);
    cyc(64'h8000_0010, 1, 1, 0, 0, 32'h0, 0);
    cyc(64'h8000_0010, 1, 0, 0, 0, 32'h0, 0);
    idle(1);

    // Flush one cycle after the request; answer four cycles later is dropped.
    cyc(64'h8000_0020, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0020, 1, 0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) cyc(64'h8000_0020, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0020, 1, 0, 0, 1, 32'h1111_2222, 0);
    cyc(64'h8000_0030, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0030, 1, 0, 0, 1, 32'h3333_4444, 0);

    // Unmapped PC.
    cyc(64'h4000, 1, 0, 0, 0, 32'h0, 0);
    idle(2);

    // Timeout, then the late answer drains DISCARD.
    cyc(64'h8000_0040, 1, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < TIMEOUT + 6; i++) cyc(64'h8000_0040, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0040, 1, 0, 0, 1, 32'h5555_6666, 0);
    cyc(64'h200, 1, 0, 0, 0, 32'h0, 0);

    // Reset during WAIT, then a late ready in RUN is ignored.
    cyc(64'h8000_0050, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0050, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0050, 1, 0, 0, 0, 32'h0, 1);
    cyc(64'h0, 0, 0, 0, 0, 32'h0, 0);
    cyc(64'h0, 0, 0, 0, 1, 32'h7777_8888, 0);

    // Window edges, and flush with a DRAM PC in RUN.
    cyc(64'hFFC, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h1000, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h7FFF_FFFC, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h9000_0000, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8000_0060, 1, 0, 1, 0, 32'h0, 0);
    cyc(64'h8FFF_FFFC, 1, 0, 0, 0, 32'h0, 0);
    cyc(64'h8FFF_FFFC, 1, 0, 0, 1, 32'h9999_AAAA, 0);

    // Randomized traffic; the last phase makes answers rare to provoke timeouts.
    for (int i = 0; i < 3000; i++) begin
      cat = $urandom_range(0, 3);
      if (cat == 0)      pc = ROM_BASE + (64'($urandom_range(0, 1023)) << 2);
      else if (cat == 3) pc = unm[$urandom_range(0, 4)];
      else               pc = DRAM_BASE + (64'($urandom_range(0, 32'h3FF_FFFF)) << 2);
      rdy_div = (i >= 2000) ? 120 : 4;
      cyc(pc,
          ($urandom % 8) != 0,
          ($urandom % 4) == 0,
          (i >= 2000) ? (($urandom % 200) == 0) : (($urandom % 12) == 0),
          ($urandom % rdy_div) == 0,
          $urandom,
          ($urandom % 300) == 0);
    end
    idle(2);

    @(negedge clk);
    #1;
    check("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Fetch-channel controller for the split instruction-fetch stages (IFP -> IFR). It decodes the PC held in IFP and selects between the single-cycle boot ROM and the variable-latency DRAM/cache path. It issues DRAM read requests, holds the PC/IFP stage while a DRAM fetch is outstanding, and drives the DRAM-path data/ready into IFR. It also discards responses killed by a flush, buffers responses that arrive while downstream is stalled, and reports unmapped and timed-out fetches.

Parameters:
ROM_BASE, 64'h0000_0000_0000_0000, first ROM byte address
ROM_SIZE, 64'h1000, ROM window size in bytes
DRAM_BASE, 64'h0000_0000_8000_0000, first DRAM byte address
DRAM_SIZE, 64'h1000_0000, DRAM window size in bytes
TIMEOUT, 64, maximum DRAM wait cycles before a fault is declared

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
pc_IFP  in  64  PC currently held in IFP
pc_valid  in  1  pc_IFP is a real fetch (not a bubble)
stall_in  in  1  downstream pipeline stall (IFR stall)
flush  in  1  pipeline flush / redirect
dram_ready_in  in  1  DRAM/cache read data valid
dram_rdata  in  32  DRAM/cache read data
dram_req  out  1  one-cycle DRAM read request pulse
dram_addr  out  64  DRAM read address, valid with dram_req
if_channel_sel  out  1  to IFR: 1 = DRAM path, 0 = ROM
ifr_dram_dout  out  32  to IFR dram_dout
ifr_dram_ready  out  1  to IFR dram_data_ready
fetch_stall  out  1  hold PC and IFP registers
fetch_fault  out  1  one-cycle pulse: unmapped PC or DRAM timeout
fault_pc  out  64  PC of the last fault, held until the next fault

Behaviour:
- Decode (combinational): rom_hit = ROM_BASE <= pc_IFP < ROM_BASE+ROM_SIZE; dram_hit likewise for the DRAM window. Neither hit = unmapped. Compares are unsigned 64-bit; base+size must not overflow.
- States: RUN, WAIT, HOLD, DISCARD. Reset puts the FSM in RUN. On reset, all outputs and the wait counter are 0, the buffer is cleared and fault_pc is 0.
- RUN:
  - pc_valid=0 or stall_in=1: no request; if_channel_sel=0; fetch_stall=0.
  - rom_hit: if_channel_sel=0; fetch_stall=0; zero added latency.
  - dram_hit (and !stall_in, !flush): dram_req=1 and dram_addr=pc_IFP this cycle, combinationally; fetch_stall=1; if_channel_sel=1; next state WAIT; counter cleared.
  - Unmapped (and !stall_in, !flush): fetch_fault=1 for one cycle; fault_pc<=pc_IFP; no request; fetch_stall=0.
- WAIT: if_channel_sel=1, fetch_stall=1, ifr_dram_ready=0 (IFR inserts bubbles). Counter increments each cycle.
  - dram_ready_in & !stall_in & !flush: ifr_dram_ready=1 and ifr_dram_dout=dram_rdata this cycle; fetch_stall=0; next state RUN. This is a single-cycle accept; PC advances on the same edge that IFR captures.
  - dram_ready_in & stall_in & !flush: capture dram_rdata into the 32-bit buffer; next state HOLD.
  - flush (with or without ready): next state DISCARD, or RUN if ready arrives in the same cycle. The response is never presented to IFR.
  - Counter reaches TIMEOUT with no ready: fetch_fault pulse; fault_pc<=pc_IFP; next state DISCARD.
- HOLD: if_channel_sel=1; ifr_dram_dout=buffer; ifr_dram_ready=1; fetch_stall=1 while stall_in=1.
  - On the first cycle with stall_in=0: fetch_stall=0; next state RUN.
  - flush in HOLD: drop the buffer; next state RUN.
- DISCARD: fetch_stall=1; ifr_dram_ready=0; if_channel_sel=1. The next state is RUN in the cycle dram_ready_in=1; that data is dropped.
  - A new flush in DISCARD keeps the state. There is no second timeout: DRAM is required to answer eventually.
- Only one DRAM request is outstanding at any time; dram_req is never asserted outside RUN.
- Simultaneous flush and a new DRAM/unmapped PC in RUN: no request and no fault, because the PC is being redirected.
- reset asserted in any state wins over every other input. A late dram_ready_in after reset, arriving while in RUN, is ignored.

Test Plan:
- ROM fetch: pc_IFP=0x100, pc_valid=1 -> if_channel_sel=0, fetch_stall=0, dram_req=0 every cycle.
- DRAM fetch, 3-cycle latency: pc_IFP=0x8000_0000 -> dram_req pulse with dram_addr=0x8000_0000; fetch_stall=1 for 3 cycles; on the ready cycle ifr_dram_ready=1 and ifr_dram_dout=0x0000_0013; then RUN.
- Ready during stall: ready with rdata=0xDEAD_BEEF while stall_in=1 for 2 cycles -> HOLD; ifr_dram_ready=1 and dout=0xDEAD_BEEF held; release on the first cycle stall_in=0.
- Flush mid-wait: flush one cycle after the request, ready 4 cycles later -> ifr_dram_ready never 1; fetch_stall high until that ready; next fetch proceeds normally.
- Unmapped: pc_IFP=0x4000 -> single fetch_fault pulse, fault_pc=0x4000, no dram_req.
- Timeout with TIMEOUT=64: no ready for 64 cycles -> fetch_fault pulse, state DISCARD; a later ready returns to RUN. Reset asserted during WAIT -> all outputs 0 on the next cycle.
